// File: rtl/dmem_arb_if.sv
// Bundle of both requester ports and the memory port of dmem_arbiter.
// slave = arbiter side, master = requesters and memory model side.
interface dmem_arb_if #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
);
    localparam int BW = DWIDTH / 8;

    logic              req0_valid;
    logic              req0_ready;
    logic [BW-1:0]     req0_we;
    logic              req0_lock;
    logic [AWIDTH-1:0] req0_addr;
    logic [DWIDTH-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DWIDTH-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic [BW-1:0]     req1_we;
    logic              req1_lock;
    logic [AWIDTH-1:0] req1_addr;
    logic [DWIDTH-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DWIDTH-1:0] rsp1_rdata;

    logic              mem_en;
    logic [BW-1:0]     mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic [DWIDTH-1:0] mem_dout;

    modport slave (
        input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/accelerator) data memory arbiter with bus lock and grant counters.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin.
module dmem_arbiter #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    dmem_arb_if.slave   bus,
    input  logic        cnt_clr,
    output logic [31:0] gnt_cnt0,
    output logic [31:0] gnt_cnt1
);
    localparam int BW = DWIDTH / 8;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_t;

    lock_t             r_lock;
    logic              r_rsp0;
    logic              r_rsp1;
    logic              r_rd0;
    logic              r_rd1;
    logic [31:0]       r_cnt0;
    logic [31:0]       r_cnt1;

    logic              w_fav0;
    logic              w_g0;
    logic              w_g1;
    logic              w_xfer;
    logic              w_lock;
    logic [AWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_din;
    logic [BW-1:0]     w_we;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_fav0 = 1'b1;
`else
    logic r_prio;

    // r_prio names the requester favoured on the next contested cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (w_xfer) begin
            r_prio <= w_g0;
        end
    end

    assign w_fav0 = ~r_prio;
`endif

    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (rst) begin
            unique case (r_lock)
                UNLOCKED: begin
                    w_g0 = bus.req0_valid &&
                           (!bus.req1_valid || w_fav0);
                    w_g1 = bus.req1_valid && !w_g0;
                end
                LOCKED0: w_g0 = bus.req0_valid;
                LOCKED1: w_g1 = bus.req1_valid;
                default: ;
            endcase
        end
    end

    assign w_xfer = w_g0 | w_g1;
    assign w_lock = w_g1 ? bus.req1_lock : bus.req0_lock;
    assign w_addr = w_g1 ? bus.req1_addr : bus.req0_addr;
    assign w_din  = w_g1 ? bus.req1_wdata : bus.req0_wdata;
    assign w_we   = w_g0 ? bus.req0_we :
                    (w_g1 ? bus.req1_we : '0);

    assign bus.req0_ready = w_g0;
    assign bus.req1_ready = w_g1;
    assign bus.mem_en     = w_xfer;
    assign bus.mem_we     = w_we;
    assign bus.mem_addr   = w_addr;
    assign bus.mem_din    = w_din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock <= UNLOCKED;
            r_rsp0 <= 1'b0;
            r_rsp1 <= 1'b0;
            r_rd0  <= 1'b0;
            r_rd1  <= 1'b0;
        end else begin
            r_rsp0 <= w_g0;
            r_rsp1 <= w_g1;
            r_rd0  <= w_g0 && (bus.req0_we == '0);
            r_rd1  <= w_g1 && (bus.req1_we == '0);
            // Only the owner can transfer while locked, so lock=0 always frees
            if (w_xfer) begin
                if (w_lock) begin
                    r_lock <= w_g1 ? LOCKED1 : LOCKED0;
                end else begin
                    r_lock <= UNLOCKED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (cnt_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_g0) r_cnt0 <= r_cnt0 + 32'd1;
            if (w_g1) r_cnt1 <= r_cnt1 + 32'd1;
        end
    end

    assign bus.rsp0_valid = r_rsp0;
    assign bus.rsp1_valid = r_rsp1;
    assign bus.rsp0_rdata = r_rd0 ? bus.mem_dout : '0;
    assign bus.rsp1_rdata = r_rd1 ? bus.mem_dout : '0;
    assign gnt_cnt0       = r_cnt0;
    assign gnt_cnt1       = r_cnt1;
endmodule
